// File: rtl/sram_controller_pkg.sv
// Shared types and defaults for the MEM-stage to 16-bit asynchronous SRAM bridge.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLo   = 2'd1,
        StHi   = 2'd2,
        StDone = 2'd3
    } sram_state_e;

    localparam logic [31:0] DefBaseAddr     = 32'd1024;
    localparam int unsigned DefSramAw       = 18;
    localparam int unsigned DefAccessCycles = 2;

    // Byte offset into data memory; wraps at 32 bits, no range check.
    function automatic logic [31:0] dmem_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/sram_controller.sv
// Multi-cycle bridge splitting each 32-bit load/store into two half-word accesses
// on an external asynchronous SRAM; ready drops while an access is in flight.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = DefBaseAddr,
    parameter int unsigned SRAM_AW       = DefSramAw,
    parameter int unsigned ACCESS_CYCLES = DefAccessCycles
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [15:0]        sram_dq_in,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int unsigned CntW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ACCESS_CYCLES - 1);

    sram_state_e        state_q;
    logic [CntW-1:0]    cnt_q;
    logic               op_wr_q;
    logic [SRAM_AW-2:0] word_q;
    logic [31:0]        wdata_q;

    logic [31:0] off;
    logic        unused_off;
    logic        req;
    logic        last;
    logic        active;
    logic        in_hi;

    assign off        = dmem_offset(address, BASE_ADDR);
    assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};
    assign req        = rd_en | wr_en;
    assign last       = (cnt_q == CntLast);
    assign active     = (state_q == StLo) || (state_q == StHi);
    assign in_hi      = (state_q == StHi);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_wr_q   <= 1'b0;
            word_q    <= '0;
            wdata_q   <= '0;
            read_data <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        word_q  <= off[SRAM_AW:2];
                        wdata_q <= write_data;
                        op_wr_q <= wr_en;
                        cnt_q   <= '0;
                        state_q <= StLo;
                    end
                end
                StLo: begin
                    if (last) begin
                        if (!op_wr_q) read_data[15:0] <= sram_dq_in;
                        cnt_q   <= '0;
                        state_q <= StHi;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StHi: begin
                    if (last) begin
                        if (!op_wr_q) read_data[31:16] <= sram_dq_in;
                        cnt_q   <= '0;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    // A request still held here was already served; do not restart it.
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        ready = 1'b0;
        unique case (state_q)
            StIdle:  ready = ~req;
            StDone:  ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Strobes come only from registered state so they stay glitch-free at the pads.
    // we_n rises on the last cycle of each phase to hold address/data across the write edge.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = 16'h0000;
        if (active) sram_addr = {word_q, in_hi};
        if (state_q == StLo) sram_dq_out = wdata_q[15:0];
        if (state_q == StHi) sram_dq_out = wdata_q[31:16];
    end

    assign sram_ce_n  = ~active;
    assign sram_oe_n  = ~(active & ~op_wr_q);
    assign sram_dq_oe = active & op_wr_q;
    assign sram_we_n  = ~(active & op_wr_q & ~last);
    assign sram_ub_n  = 1'b0;
    assign sram_lb_n  = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Directed self-checking bench for sram_controller with a small behavioural SRAM.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_in;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    int total = 0;
    int passed = 0;

    logic [15:0] mem [16];
    logic        mem_init = 1'b1;

    always #5 clk = ~clk;

    sram_controller dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_ub_n   (sram_ub_n),
        .sram_lb_n   (sram_lb_n)
    );

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
        end else if (!sram_ce_n && !sram_we_n) begin
            mem[sram_addr[3:0]] <= sram_dq_out;
        end
    end

    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[3:0]] : 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Called right after driving a request on a falling edge; returns in the ready=1 cycle.
    task automatic run_access(output int low, output int we_low, output int oe_low,
                              output logic [17:0] a_first, output logic [17:0] a_last);
        bit done;
        bit first;
        done    = 1'b0;
        first   = 1'b1;
        low     = 0;
        we_low  = 0;
        oe_low  = 0;
        a_first = '0;
        a_last  = '0;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (ready) begin
                done = 1'b1;
            end else begin
                low++;
                if (!sram_we_n) we_low++;
                if (!sram_oe_n) oe_low++;
                if (!sram_ce_n) begin
                    if (first) a_first = sram_addr;
                    first  = 1'b0;
                    a_last = sram_addr;
                end
                @(negedge clk);
            end
        end
    endtask

    int          low;
    int          we_low;
    int          oe_low;
    logic [17:0] a0;
    logic [17:0] a1;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_strobes", {29'd0, sram_we_n, sram_ce_n, sram_oe_n}, 32'h7);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_read_data", read_data, 32'h0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("ub_lb", {30'd0, sram_ub_n, sram_lb_n}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Store 0xDEADBEEF at 1028 -> half-words 2 (BEEF) and 3 (DEAD)
        wr_en = 1'b1; address = 32'd1028; write_data = 32'hDEADBEEF;
        run_access(low, we_low, oe_low, a0, a1);
        check("st_stall", 32'(low), 32'd5);
        check("st_we_cycles", 32'(we_low), 32'd2);
        check("st_oe_cycles", 32'(oe_low), 32'd0);
        check("st_addr_lo", 32'(a0), 32'd2);
        check("st_addr_hi", 32'(a1), 32'd3);
        check("st_done_ce", 32'(sram_ce_n), 32'd1);
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        check("st_ready_after", 32'(ready), 32'd1);
        check("st_mem2", 32'(mem[2]), 32'h0000BEEF);
        check("st_mem3", 32'(mem[3]), 32'h0000DEAD);
        check("st_read_data", read_data, 32'h0);

        // Load from 1028, held through DONE
        @(negedge clk);
        rd_en = 1'b1; address = 32'd1028;
        run_access(low, we_low, oe_low, a0, a1);
        check("ld_stall", 32'(low), 32'd5);
        check("ld_we_cycles", 32'(we_low), 32'd0);
        check("ld_oe_cycles", 32'(oe_low), 32'd4);
        check("ld_read_data", read_data, 32'hDEADBEEF);

        // Back-to-back: store to 1032 starts from IDLE on the next cycle
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b1; address = 32'd1032; write_data = 32'h12345678;
        run_access(low, we_low, oe_low, a0, a1);
        check("b2b_stall", 32'(low), 32'd5);
        check("b2b_oe_cycles", 32'(oe_low), 32'd0);
        check("b2b_addr_lo", 32'(a0), 32'd4);
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        check("b2b_mem4", 32'(mem[4]), 32'h00005678);
        check("b2b_mem5", 32'(mem[5]), 32'h00001234);
        check("b2b_read_data", read_data, 32'hDEADBEEF);

        // Both rd_en and wr_en: store wins
        @(negedge clk);
        rd_en = 1'b1; wr_en = 1'b1; address = 32'd1036; write_data = 32'hA5A55A5A;
        run_access(low, we_low, oe_low, a0, a1);
        check("both_stall", 32'(low), 32'd5);
        check("both_oe_cycles", 32'(oe_low), 32'd0);
        check("both_we_cycles", 32'(we_low), 32'd2);
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        #1;
        check("both_mem6", 32'(mem[6]), 32'h00005A5A);
        check("both_mem7", 32'(mem[7]), 32'h0000A5A5);
        check("both_read_data", read_data, 32'hDEADBEEF);

        // Reset pulse during HI of a store
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        #1;
        check("abort_in_hi", {30'd0, sram_ce_n, sram_dq_oe}, 32'h1);
        check("abort_hi_addr", 32'(sram_addr), 32'd9);
        rst = 1'b0; wr_en = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_strobes", {29'd0, sram_we_n, sram_ce_n, sram_oe_n}, 32'h7);
        check("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("abort_addr", 32'(sram_addr), 32'd0);
        check("abort_read_data", read_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rd_en = 1'b1; address = 32'd1028;
        run_access(low, we_low, oe_low, a0, a1);
        check("post_ld_stall", 32'(low), 32'd5);
        check("post_ld_data", read_data, 32'hDEADBEEF);
        @(negedge clk);
        rd_en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
